// File: rtl/dmem_if.sv
// Load/store request and response bus between the MEM stage (master) and the
// data-memory responder (slave).
interface dmem_if;
  logic        req_valid;
  logic        req_ready;
  logic [3:0]  req_wen;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_rdata;

  modport master (
    output req_valid, req_wen, req_addr, req_wdata, rsp_ready,
    input  req_ready, rsp_valid, rsp_rdata
  );

  modport slave (
    input  req_valid, req_wen, req_addr, req_wdata, rsp_ready,
    output req_ready, rsp_valid, rsp_rdata
  );
endinterface

// File: rtl/dmem_responder.sv
// Multi-cycle data-memory responder: one outstanding load/store, response after
// LATENCY cycles, held until accepted; plus a registered read-only display port.
module dmem_responder #(
  parameter int ADDR_W  = 8,
  parameter int LATENCY = 2
) (
  input  logic        clk,
  input  logic        reset,
  dmem_if.slave       bus,
  input  logic        cancel,
  input  logic [31:0] test_addr,
  output logic [31:0] test_data
);
  localparam int         DEPTH    = 1 << ADDR_W;
  localparam logic [3:0] CNT_INIT = 4'(LATENCY - 1);

  typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

  state_t            state, state_nxt;
  logic [3:0]        cnt, cnt_nxt;
  logic [31:0]       hold_q;
  logic [31:0]       rdata_q;
  logic [31:0]       mem [DEPTH];
  logic [ADDR_W-1:0] req_idx;
  logic [ADDR_W-1:0] test_idx;
  logic [31:0]       rd_word;
  logic              accept;
  logic              load_direct;
  logic              load_hold;
  logic              unused_addr_bits;

  assign req_idx  = bus.req_addr[ADDR_W+1:2];
  assign test_idx = test_addr[ADDR_W+1:2];
  assign unused_addr_bits = ^{bus.req_addr[31:ADDR_W+2], bus.req_addr[1:0],
                              test_addr[31:ADDR_W+2], test_addr[1:0]};

  // Stores answer with zero; loads see memory before this edge's (absent) write.
  assign rd_word = (bus.req_wen == 4'b0000) ? mem[req_idx] : 32'd0;

  assign bus.req_ready = !reset && !cancel &&
                         (state == IDLE || (state == RESP && bus.rsp_ready));
  assign accept        = bus.req_valid && bus.req_ready;
  assign bus.rsp_valid = (state == RESP);
  assign bus.rsp_rdata = rdata_q;

  // Two ways into RESP: straight from an accept, or the last BUSY cycle.
  assign load_direct = accept && (LATENCY == 1);
  assign load_hold   = (state == BUSY) && (cnt == 4'd1) && !cancel;

  // NOTE: every output of this block gets a default first, so no path leaves one unassigned and no latch is inferred.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    case (state)
      IDLE, RESP: begin
        if (accept) begin
          state_nxt = (LATENCY == 1) ? RESP : BUSY;
          cnt_nxt   = CNT_INIT;
        end else if (state == RESP && bus.rsp_ready) begin
          state_nxt = IDLE;
        end
      end
      BUSY: begin
        cnt_nxt = cnt - 4'd1;
        if (cnt == 4'd1) state_nxt = RESP;
      end
      default: state_nxt = IDLE;
    endcase
    if (cancel) begin
      state_nxt = IDLE;
      cnt_nxt   = 4'd0;
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      cnt       <= 4'd0;
      hold_q    <= 32'd0;
      rdata_q   <= 32'd0;
      test_data <= 32'd0;
    end else begin
      state     <= state_nxt;
      cnt       <= cnt_nxt;
      test_data <= mem[test_idx];
      if (accept) hold_q <= rd_word;
      if (load_direct)    rdata_q <= rd_word;
      else if (load_hold) rdata_q <= hold_q;
    end
  end

  // NOTE: the array has no reset so it maps onto RAM; committed stores survive reset and cancel.
  always_ff @(posedge clk) begin
    if (accept) begin
      for (int b = 0; b < 4; b++) begin
        if (bus.req_wen[b]) mem[req_idx][8*b +: 8] <= bus.req_wdata[8*b +: 8];
      end
    end
  end
endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: a LATENCY=2 and a LATENCY=1 instance, each checked
// every cycle against a countdown/scoreboard model, plus directed scenarios.
module tb_dmem_responder;
  localparam int ADDR_W = 8;
  localparam int DEPTH  = 1 << ADDR_W;

  logic        clk = 1'b0;
  logic        reset;
  logic        v      [2];
  logic [3:0]  wen    [2];
  logic [31:0] addr   [2];
  logic [31:0] wdata  [2];
  logic        rr     [2];
  logic        cancel [2];
  logic [31:0] taddr  [2];
  logic        rdy_o  [2];
  logic        rv_o   [2];
  logic [31:0] rd_o   [2];
  logic [31:0] td_o   [2];

  int vectors;
  int miscompares;

  // Reference model: one countdown per instance until the response is visible.
  logic [31:0] m_mem   [2][DEPTH];
  bit          m_known [2][DEPTH];
  bit          m_pend  [2];
  int          m_wait  [2];
  logic [31:0] m_pdata [2];
  logic [31:0] m_last  [2];
  logic [31:0] m_td    [2];
  bit          m_tdk   [2];
  bit          m_acc   [2];

  logic [31:0] t6_addr [4];
  logic [31:0] t6_exp  [4];
  int          fidx    [2];

  always #5 clk = ~clk;

  dmem_if bus_a ();
  dmem_if bus_b ();

  assign bus_a.req_valid = v[0];
  assign bus_a.req_wen   = wen[0];
  assign bus_a.req_addr  = addr[0];
  assign bus_a.req_wdata = wdata[0];
  assign bus_a.rsp_ready = rr[0];
  assign rdy_o[0]        = bus_a.req_ready;
  assign rv_o[0]         = bus_a.rsp_valid;
  assign rd_o[0]         = bus_a.rsp_rdata;

  assign bus_b.req_valid = v[1];
  assign bus_b.req_wen   = wen[1];
  assign bus_b.req_addr  = addr[1];
  assign bus_b.req_wdata = wdata[1];
  assign bus_b.rsp_ready = rr[1];
  assign rdy_o[1]        = bus_b.req_ready;
  assign rv_o[1]         = bus_b.rsp_valid;
  assign rd_o[1]         = bus_b.rsp_rdata;

  dmem_responder #(.ADDR_W(ADDR_W), .LATENCY(2)) dut_a (
    .clk       (clk),
    .reset     (reset),
    .bus       (bus_a),
    .cancel    (cancel[0]),
    .test_addr (taddr[0]),
    .test_data (td_o[0])
  );

  dmem_responder #(.ADDR_W(ADDR_W), .LATENCY(1)) dut_b (
    .clk       (clk),
    .reset     (reset),
    .bus       (bus_b),
    .cancel    (cancel[1]),
    .test_addr (taddr[1]),
    .test_data (td_o[1])
  );

  function automatic int lat_of(int k);
    return (k == 0) ? 2 : 1;
  endfunction

  function automatic logic [31:0] fill_val(int i);
    return 32'hC0DE0000 ^ (32'(i) * 32'h00010203);
  endfunction

  function automatic bit exp_ready(int k);
    return !reset && !cancel[k] && (!m_pend[k] || (m_wait[k] == 0 && rr[k]));
  endfunction

  function automatic void model_edge(int k, bit rdy);
    logic [ADDR_W-1:0] i;
    logic [ADDR_W-1:0] t;
    logic [31:0]       d;
    m_acc[k] = 1'b0;
    if (reset) begin
      m_pend[k] = 1'b0;
      m_wait[k] = 0;
      m_last[k] = '0;
      m_td[k]   = '0;
      m_tdk[k]  = 1'b1;
      return;
    end
    t        = taddr[k][ADDR_W+1:2];
    m_td[k]  = m_mem[k][t];
    m_tdk[k] = m_known[k][t];
    if (cancel[k]) begin
      m_pend[k] = 1'b0;
      return;
    end
    if (m_pend[k]) begin
      if (m_wait[k] == 0) begin
        if (rr[k]) m_pend[k] = 1'b0;
      end else begin
        m_wait[k]--;
        if (m_wait[k] == 0) m_last[k] = m_pdata[k];
      end
    end
    if (v[k] && rdy) begin
      m_acc[k] = 1'b1;
      i = addr[k][ADDR_W+1:2];
      d = (wen[k] == 4'h0) ? m_mem[k][i] : 32'd0;
      for (int b = 0; b < 4; b++)
        if (wen[k][b]) m_mem[k][i][8*b +: 8] = wdata[k][8*b +: 8];
      if (wen[k] == 4'hF) m_known[k][i] = 1'b1;
      m_pend[k] = 1'b1;
      m_wait[k] = lat_of(k) - 1;
      if (m_wait[k] == 0) m_last[k] = d;
      else                m_pdata[k] = d;
    end
  endfunction

  task automatic check(string tag, int k, logic [31:0] obs, logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s dut%0d: observed %h expected %h", tag, k, obs, exp);
    end
  endtask

  // Compare all outputs at the falling edge, then advance the model at the rising edge.
  task automatic tick();
    bit rdy_exp [2];
    @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      rdy_exp[k] = exp_ready(k);
      check("req_ready", k, 32'(rdy_o[k]), 32'(rdy_exp[k]));
      check("rsp_valid", k, 32'(rv_o[k]), 32'(m_pend[k] && m_wait[k] == 0));
      check("rsp_rdata", k, rd_o[k], m_last[k]);
      if (m_tdk[k]) check("test_data", k, td_o[k], m_td[k]);
    end
    @(posedge clk);
    for (int k = 0; k < 2; k++) model_edge(k, rdy_exp[k]);
    #1;
  endtask

  task automatic issue(int k, logic [3:0] we, logic [31:0] a, logic [31:0] wd);
    int n;
    n = 0;
    v[k] = 1'b1; wen[k] = we; addr[k] = a; wdata[k] = wd;
    do begin
      tick();
      n++;
    end while (!m_acc[k] && n < 20);
    v[k] = 1'b0;
    if (!m_acc[k]) check("accept_timeout", k, 32'(n), 32'd0);
  endtask

  task automatic get_rsp(int k, output logic [31:0] d, output int n);
    d = '0;
    n = 0;
    rr[k] = 1'b1;
    #1;
    while (!rv_o[k] && n < 20) begin
      tick();
      n++;
    end
    if (n >= 20) check("rsp_timeout", k, 32'(n), 32'd0);
    d = rd_o[k];
    tick();
  endtask

  initial begin
    logic [31:0] d;
    logic [31:0] held;
    int          n;

    vectors = 0;
    miscompares = 0;
    reset = 1'b1;
    for (int k = 0; k < 2; k++) begin
      v[k] = 1'b0; wen[k] = 4'h0; addr[k] = '0; wdata[k] = '0;
      rr[k] = 1'b1; cancel[k] = 1'b0; taddr[k] = '0;
      m_pend[k] = 1'b0; m_wait[k] = 0; m_pdata[k] = '0; m_last[k] = '0;
      m_td[k] = '0; m_tdk[k] = 1'b0; m_acc[k] = 1'b0;
      for (int i = 0; i < DEPTH; i++) m_known[k][i] = 1'b0;
    end
    t6_addr[0] = 32'h000; t6_addr[1] = 32'h004; t6_addr[2] = 32'h008; t6_addr[3] = 32'h400;
    t6_exp[0] = fill_val(0); t6_exp[1] = fill_val(1); t6_exp[2] = fill_val(2); t6_exp[3] = fill_val(0);

    // Power-up reset with a store presented: nothing may be accepted.
    for (int k = 0; k < 2; k++) begin
      v[k] = 1'b1; wen[k] = 4'hF; addr[k] = 32'h10; wdata[k] = 32'h0BAD0BAD;
    end
    repeat (3) begin
      tick();
      check("rst_ready", 0, 32'(rdy_o[0]), 32'd0);
      check("rst_valid", 0, 32'(rv_o[0]), 32'd0);
      check("rst_rdata", 0, rd_o[0], 32'd0);
    end
    v[0] = 1'b0; v[1] = 1'b0;
    reset = 1'b0;
    tick();

    // Fill both memories with a known pattern.
    fidx[0] = 0; fidx[1] = 0;
    for (int n2 = 0; n2 < 4 * DEPTH && (fidx[0] < DEPTH || fidx[1] < DEPTH); n2++) begin
      for (int k = 0; k < 2; k++) begin
        v[k]     = (fidx[k] < DEPTH);
        wen[k]   = 4'hF;
        addr[k]  = 32'(fidx[k]) << 2;
        wdata[k] = fill_val(fidx[k]);
      end
      tick();
      for (int k = 0; k < 2; k++) if (m_acc[k]) fidx[k]++;
    end
    v[0] = 1'b0; v[1] = 1'b0;
    check("fill_done", 0, 32'(fidx[0]), 32'(DEPTH));
    check("fill_done", 1, 32'(fidx[1]), 32'(DEPTH));
    tick();

    // Reset again mid-stream with a store presented: memory must be untouched.
    taddr[0] = 32'h10;
    reset = 1'b1;
    v[0] = 1'b1; wen[0] = 4'hF; addr[0] = 32'h10; wdata[0] = 32'h0BAD0BAD;
    repeat (3) begin
      tick();
      check("rst2_ready", 0, 32'(rdy_o[0]), 32'd0);
      check("rst2_valid", 0, 32'(rv_o[0]), 32'd0);
    end
    v[0] = 1'b0;
    reset = 1'b0;
    tick();
    check("rst_no_write", 0, td_o[0], fill_val(4));

    // Store then load, LATENCY=2.
    issue(0, 4'hF, 32'h10, 32'hDEADBEEF);
    get_rsp(0, d, n);
    check("t2_store_rdata", 0, d, 32'd0);
    check("t2_store_lat", 0, 32'(n), 32'd1);
    issue(0, 4'h0, 32'h10, 32'h0);
    get_rsp(0, d, n);
    check("t2_load_rdata", 0, d, 32'hDEADBEEF);
    check("t2_load_lat", 0, 32'(n), 32'd1);
    check("t2_display", 0, td_o[0], 32'hDEADBEEF);

    // Byte enables.
    issue(0, 4'hF, 32'h20, 32'h11223344);
    get_rsp(0, d, n);
    issue(0, 4'b0101, 32'h20, 32'hAABBCCDD);
    get_rsp(0, d, n);
    issue(0, 4'h0, 32'h20, 32'h0);
    get_rsp(0, d, n);
    check("t3_merge", 0, d, 32'h11BB33DD);

    // Backpressure: response held, no new accept, then hand-off plus accept.
    rr[0] = 1'b0;
    issue(0, 4'h0, 32'h10, 32'h0);
    n = 0;
    while (!rv_o[0] && n < 20) begin
      tick();
      n++;
    end
    held = rd_o[0];
    check("t4_data", 0, held, 32'hDEADBEEF);
    v[0] = 1'b1; wen[0] = 4'h0; addr[0] = 32'h20;
    repeat (5) begin
      tick();
      check("t4_valid", 0, 32'(rv_o[0]), 32'd1);
      check("t4_rdata", 0, rd_o[0], held);
      check("t4_ready", 0, 32'(rdy_o[0]), 32'd0);
    end
    rr[0] = 1'b1;
    #1;
    check("t4_ready_hs", 0, 32'(rdy_o[0]), 32'd1);
    tick();
    v[0] = 1'b0;
    get_rsp(0, d, n);
    check("t4_next_rdata", 0, d, 32'h11BB33DD);

    // Cancel while busy: the response never appears.
    issue(0, 4'h0, 32'h10, 32'h0);
    cancel[0] = 1'b1;
    tick();
    cancel[0] = 1'b0;
    #1;
    check("t5_idle_ready", 0, 32'(rdy_o[0]), 32'd1);
    repeat (4) begin
      tick();
      check("t5_no_rsp", 0, 32'(rv_o[0]), 32'd0);
    end
    issue(0, 4'hF, 32'h30, 32'h5A5A1234);
    cancel[0] = 1'b1;
    tick();
    cancel[0] = 1'b0;
    issue(0, 4'h0, 32'h30, 32'h0);
    get_rsp(0, d, n);
    check("t5_store_kept", 0, d, 32'h5A5A1234);

    // LATENCY=1 streaming, including the 0x400 alias of word 0.
    rr[1] = 1'b1; v[1] = 1'b1; wen[1] = 4'h0;
    for (int i = 0; i < 4; i++) begin
      addr[1] = t6_addr[i];
      tick();
      check("t6_valid", 1, 32'(rv_o[1]), 32'd1);
      check("t6_data", 1, rd_o[1], t6_exp[i]);
    end
    v[1] = 1'b0;
    tick();
    check("t6_drain", 1, 32'(rv_o[1]), 32'd0);

    // Random traffic on both instances against the model.
    for (int n3 = 0; n3 < 800; n3++) begin
      reset = ($urandom_range(0, 99) == 0);
      for (int k = 0; k < 2; k++) begin
        v[k]      = ($urandom_range(0, 9) < 7);
        wen[k]    = ($urandom_range(0, 1) == 1) ? 4'h0 : 4'($urandom_range(1, 15));
        addr[k]   = $urandom();
        wdata[k]  = $urandom();
        rr[k]     = ($urandom_range(0, 9) < 7);
        cancel[k] = ($urandom_range(0, 19) == 0);
        taddr[k]  = $urandom();
      end
      tick();
    end
    reset = 1'b0;
    for (int k = 0; k < 2; k++) begin
      v[k] = 1'b0; cancel[k] = 1'b0; rr[k] = 1'b1;
    end
    repeat (5) tick();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
